// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst memory slave: burst encodings,
// response codes and the write/read channel state types.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed storage with a byte-strobed write port and an asynchronous
// read port; the caller registers the read data.
module axi_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_WIDTH-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_WIDTH-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Reading the array combinationally lets a same-edge write leave the old word in the caller's register.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs in front of a
// word-addressed array; INCR/WRAP step one word per beat, FIXED holds.
module axi_burst_mem_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IDX_WIDTH = $clog2(MEM_DEPTH);

  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a, input burst_e b);
    return (b == FIXED) ? a : a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  logic unused_size;
  assign unused_size = ^{awsize, arsize};

  w_state_e              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  burst_e                w_burst;
  logic                  w_err;
  logic                  aw_hs, w_hs;

  r_state_e              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_adv_addr, fetch_addr;
  logic [7:0]            r_len, r_cnt, r_adv_cnt, fetch_cnt;
  burst_e                r_burst;
  logic                  ar_hs, r_hs, r_load;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = w_id;
  assign bresp   = w_err ? SLVERR : OKAY;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid) w_next = W_DATA;
      W_DATA:  if (wvalid && wlast) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Length mismatch is only judged at the wlast beat; extra beats keep counting up to 255.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= FIXED;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_burst <= burst_e'(awburst);
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= advance(w_addr, w_burst);
      if (w_cnt != 8'hFF) w_cnt <= w_cnt + 8'd1;
      if (!in_range(w_addr) || (wlast && (w_cnt != w_len))) w_err <= 1'b1;
    end
  end

  assign arready    = (r_state == R_IDLE);
  assign rvalid     = (r_state == R_DATA);
  assign ar_hs      = arvalid && arready;
  assign r_hs       = rready && rvalid;
  assign r_adv_addr = advance(r_addr, r_burst);
  assign r_adv_cnt  = r_cnt + 8'd1;
  assign fetch_addr = (r_state == R_DATA) ? r_adv_addr : r_addr;
  assign fetch_cnt  = (r_state == R_DATA) ? r_adv_cnt : r_cnt;
  assign r_load     = (r_state == R_FETCH) || (r_hs && !rlast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (rready && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // The next beat is fetched from the advanced address on the handshake edge so beats stream back-to-back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= FIXED;
      r_cnt   <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id    <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_burst <= burst_e'(arburst);
        r_cnt   <= '0;
      end else if (r_hs && !rlast) begin
        r_addr <= r_adv_addr;
        r_cnt  <= r_adv_cnt;
      end
      if (r_load) begin
        rid   <= r_id;
        rdata <= in_range(fetch_addr) ? mem_rdata : '0;
        rresp <= in_range(fetch_addr) ? OKAY : SLVERR;
        rlast <= (fetch_cnt == r_len);
      end
    end
  end

  axi_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (w_hs && in_range(w_addr)),
    .waddr(w_addr[IDX_WIDTH-1:0]),
    .wdata(wdata),
    .wstrb(wstrb),
    .raddr(fetch_addr[IDX_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized bench for axi_burst_mem_slave: a word-array reference model is
// updated from the burst rules and read bursts are compared beat by beat.
module tb_axi_burst_mem_slave;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0, resetn = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;

  always #5 clk = ~clk;

  axi_burst_mem_slave dut (
    .clk(clk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int vectors = 0, miscompares = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rdat [256];
  logic [1:0]  rrsp [256];
  logic        rlst [256];
  logic [3:0]  rrid [256];
  int          rn, r_lat, r_stall_bad, r_gaps, w_wait, b_lat;
  logic [3:0]  got_bid;
  logic [1:0]  got_bresp;

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst, input int b);
    return (burst == 2'b00) ? base : base + 32'(b);
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] a);
    return (a < DEPTH) ? model[a[9:0]] : 32'h0;
  endfunction

  // Reference write: applies strobed bytes of in-range beats, returns the response the burst deserves.
  task automatic model_write(input logic [31:0] base, input logic [1:0] burst, input logic [7:0] len,
                             input int nbeats, output logic [1:0] resp);
    logic        err;
    logic [31:0] a;
    err = ((nbeats - 1) != int'(len));
    for (int b = 0; b < nbeats; b++) begin
      a = beat_addr(base, burst, b);
      if (a < DEPTH) begin
        for (int i = 0; i < 4; i++)
          if (ws[b][i]) model[a[9:0]][i*8 +: 8] = wd[b][i*8 +: 8];
      end else err = 1'b1;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats);
    int k;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    k = 0;
    while (!awready && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    awvalid = 1'b0;
    w_wait = 0;
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1);
      k = 0;
      while (!wready && k < 200) begin @(negedge clk); k++; end
      if (b == 0) w_wait = k;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_lat = 0;
    while (!bvalid && b_lat < 200) begin @(negedge clk); b_lat++; end
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("[TB] FAIL write_timeout: bvalid got 0 want 1");
    end
    got_bid = bid; got_bresp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // mode 0: rready held high, 1: toggles 1/0 each cycle, 2: random.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int mode);
    int k;
    logic stalled, done, hl;
    logic [31:0] hd;
    logic [1:0] hr;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    arvalid = 1'b0;
    r_lat = 1;
    while (!rvalid && r_lat < 200) begin @(negedge clk); r_lat++; end
    rn = 0; r_stall_bad = 0; r_gaps = 0; stalled = 0; done = 0; k = 0;
    hd = '0; hr = '0; hl = 0;
    while (!done && k < 3000 && rn < 256) begin
      if (stalled && (!rvalid || rdata !== hd || rresp !== hr || rlast !== hl)) r_stall_bad++;
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      if (!rvalid) r_gaps++;
      if (rvalid && rready) begin
        rdat[rn] = rdata; rrsp[rn] = rresp; rlst[rn] = rlast; rrid[rn] = rid;
        rn++;
        stalled = 0;
        if (rlast) done = 1;
      end else if (rvalid) begin
        stalled = 1; hd = rdata; hr = rresp; hl = rlast;
      end
      @(negedge clk);
      k++;
    end
    rready = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("[TB] FAIL read_timeout: rlast handshake got none want one");
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rdata, rresp, rlast} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 32'h0, 2'b00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got aw=%b ar=%b w=%b bv=%b rv=%b rdata=%h want 1 1 0 0 0 0",
               awready, arready, wready, bvalid, rvalid, rdata);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_fill();
    logic [1:0] er;
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      model_write(32'(blk * 256), 2'b01, 8'd255, 256, er);
      do_write(4'(blk), 32'(blk * 256), 8'd255, 2'b01, 256);
      vectors++;
      if (got_bresp !== er || got_bid !== 4'(blk)) begin
        miscompares++;
        $display("[TB] FAIL fill_resp: got bid=%h bresp=%b want bid=%h bresp=%b", got_bid, got_bresp, 4'(blk), er);
      end
    end
  endtask

  task automatic test_incr_write_read();
    logic [1:0] er;
    for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0 + 32'(b); ws[b] = 4'hF; end
    model_write(32'h10, 2'b01, 8'd3, 4, er);
    do_write(4'h3, 32'h10, 8'd3, 2'b01, 4);
    vectors++;
    if (got_bresp !== 2'b00 || got_bid !== 4'h3 || w_wait != 0 || b_lat != 0) begin
      miscompares++;
      $display("[TB] FAIL incr_write: got bid=%h bresp=%b wwait=%0d blat=%0d want 3 00 0 0", got_bid, got_bresp, w_wait, b_lat);
    end
    do_read(4'h5, 32'h10, 8'd3, 2'b01, 0);
    vectors++;
    if (r_lat != 2 || rn != 4 || r_gaps != 0) begin
      miscompares++;
      $display("[TB] FAIL incr_read_timing: got lat=%0d beats=%0d gaps=%0d want 2 4 0", r_lat, rn, r_gaps);
    end
    for (int b = 0; b < rn && b < 4; b++) begin
      vectors++;
      if (rdat[b] !== 32'hA0 + 32'(b) || rrsp[b] !== 2'b00 || rlst[b] !== (b == 3) || rrid[b] !== 4'h5) begin
        miscompares++;
        $display("[TB] FAIL incr_read_beat%0d: got d=%h r=%b l=%b id=%h want d=%h r=00 l=%b id=5",
                 b, rdat[b], rrsp[b], rlst[b], rrid[b], 32'hA0 + 32'(b), (b == 3));
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] er;
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    model_write(32'h20, 2'b01, 8'd0, 1, er);
    do_write(4'h1, 32'h20, 8'd0, 2'b01, 1);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h1;
    model_write(32'h20, 2'b01, 8'd0, 1, er);
    do_write(4'h2, 32'h20, 8'd0, 2'b01, 1);
    do_read(4'h7, 32'h20, 8'd0, 2'b01, 0);
    vectors++;
    if (rn != 1 || rdat[0] !== 32'h112233FF || rlst[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL strobe_merge: got beats=%0d d=%h want 1 112233ff", rn, rdat[0]);
    end
  endtask

  task automatic test_fixed();
    logic [1:0] er;
    for (int b = 0; b < 3; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    model_write(32'h5, 2'b00, 8'd2, 3, er);
    do_write(4'h9, 32'h5, 8'd2, 2'b00, 3);
    vectors++;
    if (got_bresp !== 2'b00 || got_bid !== 4'h9) begin
      miscompares++;
      $display("[TB] FAIL fixed_resp: got bid=%h bresp=%b want 9 00", got_bid, got_bresp);
    end
    do_read(4'h1, 32'h5, 8'd1, 2'b01, 0);
    vectors++;
    if (rn != 2 || rdat[0] !== 32'd3 || rdat[1] !== expect_word(32'h6)) begin
      miscompares++;
      $display("[TB] FAIL fixed_data: got %h %h want 00000003 %h", rdat[0], rdat[1], expect_word(32'h6));
    end
  endtask

  task automatic test_errors();
    logic [1:0] er;
    logic [31:0] top_addr;
    top_addr = 32'(DEPTH - 1);
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    model_write(top_addr, 2'b01, 8'd1, 2, er);
    do_write(4'hA, top_addr, 8'd1, 2'b01, 2);
    vectors++;
    if (got_bresp !== 2'b10 || er !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL range_resp: got bresp=%b want 10", got_bresp);
    end
    do_read(4'h2, top_addr, 8'd1, 2'b01, 0);
    vectors++;
    if (rn != 2 || rdat[0] !== wd[0] || rrsp[0] !== 2'b00 || rdat[1] !== 32'h0 || rrsp[1] !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL range_read: got %h/%b %h/%b want %h/00 0/10", rdat[0], rrsp[0], rdat[1], rrsp[1], wd[0]);
    end
    do_read(4'h2, 32'h0, 8'd0, 2'b01, 0);
    vectors++;
    if (rdat[0] !== expect_word(32'h0)) begin
      miscompares++;
      $display("[TB] FAIL range_nowrap: got %h want %h", rdat[0], expect_word(32'h0));
    end
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    model_write(32'h40, 2'b01, 8'd3, 2, er);
    do_write(4'hB, 32'h40, 8'd3, 2'b01, 2);
    vectors++;
    if (got_bresp !== er || er !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL early_wlast: got bresp=%b want 10", got_bresp);
    end
    model_write(32'h50, 2'b01, 8'd1, 4, er);
    do_write(4'hC, 32'h50, 8'd1, 2'b01, 4);
    do_read(4'h3, 32'h50, 8'd3, 2'b01, 0);
    vectors++;
    if (got_bresp !== 2'b10 || rn != 4 || rdat[3] !== wd[3] || rdat[0] !== wd[0]) begin
      miscompares++;
      $display("[TB] FAIL late_wlast: got bresp=%b beats=%0d d3=%h want 10 4 %h", got_bresp, rn, rdat[3], wd[3]);
    end
  endtask

  task automatic test_read_stall();
    logic [1:0] er;
    for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    model_write(32'h200, 2'b01, 8'd7, 8, er);
    do_write(4'h4, 32'h200, 8'd7, 2'b01, 8);
    do_read(4'h6, 32'h200, 8'd7, 2'b01, 1);
    vectors++;
    if (rn != 8 || r_stall_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got beats=%0d unstable=%0d want 8 0", rn, r_stall_bad);
    end
    for (int b = 0; b < rn && b < 8; b++) begin
      vectors++;
      if (rdat[b] !== expect_word(32'h200 + 32'(b)) || rlst[b] !== (b == 7)) begin
        miscompares++;
        $display("[TB] FAIL stall_beat%0d: got d=%h l=%b want d=%h l=%b", b, rdat[b], rlst[b],
                 expect_word(32'h200 + 32'(b)), (b == 7));
      end
    end
  endtask

  task automatic test_random_bursts();
    logic [1:0]  er, burst;
    logic [7:0]  len;
    logic [31:0] base, a;
    logic [3:0]  id;
    for (int it = 0; it < 10; it++) begin
      burst = 2'($urandom_range(0, 2));
      len   = 8'($urandom_range(0, 15));
      base  = 32'($urandom_range(0, DEPTH + 8));
      id    = 4'($urandom);
      for (int b = 0; b <= int'(len); b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
      model_write(base, burst, len, int'(len) + 1, er);
      do_write(id, base, len, burst, int'(len) + 1);
      vectors++;
      if (got_bresp !== er || got_bid !== id) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_resp: got bid=%h bresp=%b want %h %b", it, got_bid, got_bresp, id, er);
      end
      do_read(~id, base, len, burst, $urandom_range(0, 2));
      vectors++;
      if (rn != int'(len) + 1 || r_stall_bad != 0) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_beats: got %0d unstable=%0d want %0d 0", it, rn, r_stall_bad, int'(len) + 1);
      end
      for (int b = 0; b < rn && b <= int'(len); b++) begin
        a = beat_addr(base, burst, b);
        vectors++;
        if (rdat[b] !== expect_word(a) || rrsp[b] !== ((a < DEPTH) ? 2'b00 : 2'b10) ||
            rlst[b] !== (b == int'(len)) || rrid[b] !== ~id) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_beat%0d: got d=%h r=%b l=%b id=%h want d=%h a=%h", it, b,
                   rdat[b], rrsp[b], rlst[b], rrid[b], expect_word(a), a);
        end
      end
    end
  endtask

  task automatic test_concurrent_reset();
    logic [1:0] er;
    for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    model_write(32'h300, 2'b01, 8'd7, 8, er);
    fork
      do_write(4'hD, 32'h300, 8'd7, 2'b01, 8);
      do_read(4'hE, 32'h80, 8'd7, 2'b01, 2);
    join
    vectors++;
    if (got_bresp !== 2'b00 || rn != 8 || rdat[7] !== expect_word(32'h87) || rdat[0] !== expect_word(32'h80)) begin
      miscompares++;
      $display("[TB] FAIL concurrent: got bresp=%b beats=%0d d0=%h want 00 8 %h", got_bresp, rn, rdat[0], expect_word(32'h80));
    end
    @(negedge clk);
    araddr = 32'h100; arlen = 8'd15; arburst = 2'b01; arid = 4'h8; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || awready !== 1'b1 || rlast !== 1'b0 || rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_read: got rvalid=%b arready=%b awready=%b rdata=%h want 0 1 1 0",
               rvalid, arready, awready, rdata);
    end
    @(negedge clk);
    resetn = 1'b1; rready = 1'b0;
    do_read(4'h1, 32'h300, 8'd7, 2'b01, 0);
    for (int b = 0; b < rn && b < 8; b++) begin
      vectors++;
      if (rdat[b] !== wd[b]) begin
        miscompares++;
        $display("[TB] FAIL retained_beat%0d: got %h want %h", b, rdat[b], wd[b]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_incr_write_read();
    test_strobe();
    test_fixed();
    test_errors();
    test_read_stall();
    test_random_bursts();
    test_concurrent_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

AXI4 burst-capable memory slave that sits directly downstream of the team's AXI burst memory master and terminates its five channels. It accepts INCR and FIXED write bursts into an internal word-addressed array, and returns read bursts with one-cycle initial latency and full throughput afterwards. Write and read channels run independently. It is the bench and FPGA target for the master.

## Interface
- ADDR_WIDTH, 32, address width; addresses are word indices, one word per beat.
- DATA_WIDTH, 32, data width, multiple of 8.
- ID_WIDTH, 4, transaction ID width.
- MEM_DEPTH, 1024, number of DATA_WIDTH words.
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address
- awready  out  1  write address accept
- wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data
- wready  out  1  write data accept
- bid/bresp/bvalid  out  ID_WIDTH/2/1  write response
- bready  in  1  response accept
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  read address
- arready  out  1  read address accept
- rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data
- rready  in  1  read data accept

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
- On AW handshake: latch awid, awaddr, awlen, awburst; clear the beat counter; clear the error flag.
- Each W handshake: for each byte i with wstrb[i]=1, write byte i of wdata to mem[addr]. The address must be < MEM_DEPTH; otherwise suppress the write and set the error flag.
- Address advance: FIXED (00) holds the address. INCR (01) and WRAP (10, treated as INCR) add 1 modulo 2^ADDR_WIDTH. The beat counter adds 1.
- The burst ends on the W handshake with wlast=1. If the beat counter != latched len at that beat, set the error flag. Beats without wlast past len are accepted and counted; the counter saturates at 255.
- W_RESP: bid=latched id, bresp=SLVERR (2'b10) if the error flag is set, else OKAY (2'b00). Return to W_IDLE on bvalid&&bready.
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE. arready=1 only in R_IDLE.
- R_FETCH: register rdata=mem[addr] (0 if out of range), rresp=SLVERR or OKAY per beat, rlast=(count==len), rid=latched arid.
- R_DATA: rvalid=1 and outputs are held stable until rready. On handshake with rlast=1, go to R_IDLE. Otherwise advance address and counter per the burst rule and load the next beat into the output registers in the same cycle, staying in R_DATA.
- awsize/arsize are ignored; every beat is full width.
- Same-cycle write and read to one address: read gets the old word (read-before-write).

## Timing
- Reset values: awready=1, arready=1, wready=0, bvalid=0, bid=0, bresp=0, rvalid=0, rid=0, rdata=0, rresp=0, rlast=0. Both FSMs reset to IDLE. Memory contents are not reset.
- Reset mid-burst aborts both FSMs to IDLE. Already-written words persist.
- AW handshake at cycle t: wready=1 from t+1. Write latency is 0 (data lands at the handshake edge). bvalid rises the cycle after the wlast beat.
- AR handshake at cycle t: R_FETCH at t+1, rvalid=1 at t+2. Each following beat is valid the cycle after the prior handshake when rready stays high: 1 beat/cycle.
- Ready/valid outputs are decoded from registered state only. There is no combinational input-to-output path.
- awvalid or arvalid held while busy is left pending (ready=0) and accepted on return to IDLE.

## Structure
- axi_pkg (shared): burst enum FIXED=2'b00, INCR=2'b01, WRAP=2'b10; resp constants OKAY=2'b00, SLVERR=2'b10; write/read state typedefs.
- Sub-module axi_mem_array: MEM_DEPTH x DATA_WIDTH, one byte-strobed write port and one read port registered by the caller. Both FSMs live in the top.

## Test plan
- Write INCR awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF -> 4 beats accepted, bresp=OKAY, bid=awid. Read the same -> rdata 0xA0..0xA3, rlast on beat 4, first rvalid 2 cycles after AR handshake.
- wstrb=0x1, wdata=0xFFFFFFFF over word 0x11223344 -> readback 0x112233FF.
- FIXED write awlen=2, data 1,2,3 to addr 5 -> mem[5]=3, mem[6] unchanged.
- awaddr=MEM_DEPTH-1, awlen=1 -> bresp=SLVERR, mem[MEM_DEPTH-1] written, nothing else. wlast early at beat 1 of awlen=3 -> SLVERR.
- Read awlen=7 with rready toggled 1/0 every cycle -> rdata stable while stalled, 8 beats in order, no duplicates.
- Concurrent write and read bursts, plus resetn pulse mid-read -> rvalid=0 and arready=1 immediately after reset. Written data retained.
